// File: rtl/kpd_scan.sv
// Keypad column scanner with frame-based debounce; key_state + key_any form a 13-bit pin bus at defaults.
// Optional KPD_GHOST_REJECT_EN: frames with more than two keys down never count as stable.
module kpd_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 4,
  parameter int DB_CNT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  input  logic [ROWS-1:0]      kpd_row_n,
  output logic [COLS-1:0]      kpd_col_n,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 key_any,
  output logic                 key_evt
);
  localparam int NK = ROWS * COLS;
  localparam int IW = (NK > 1) ? $clog2(NK) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DB_CNT + 1);

  typedef enum logic [1:0] {DRIVE, SAMPLE, EVAL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [DW-1:0]   div_q, div_d;
  logic            active_q;
  logic [ROWS-1:0] sync1_q, sync2_q;
  logic [NK-1:0]   raw_q, raw_d, prev_q;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            step, do_sample, do_eval, ghost, accept;

  // active_q delays the first frame by one cycle after enable so it starts clean
  assign step      = active_q && scan_en;
  assign do_sample = step && (state_q == SAMPLE);
  assign do_eval   = step && (state_q == EVAL);
  assign key_any   = |key_state;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    if (!step) begin
      state_d = DRIVE;
      col_d   = '0;
      div_d   = '0;
    end else begin
      case (state_q)
        DRIVE: begin
          if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d   = '0;
            state_d = SAMPLE;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        SAMPLE: begin
          if (col_q == CW'(COLS - 1)) begin
            state_d = EVAL;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = DRIVE;
          end
        end
        EVAL: begin
          col_d   = '0;
          state_d = DRIVE;
        end
        default: state_d = DRIVE;
      endcase
    end
  end

  always_comb begin
    kpd_col_n = '1;
    if (step && state_q == DRIVE) kpd_col_n[col_q] = 1'b0;
  end

  always_comb begin
    raw_d = raw_q;
    if (do_sample) begin
      for (int r = 0; r < ROWS; r++)
        raw_d[IW'(r * COLS) + IW'(col_q)] = ~sync2_q[r];
    end
  end

`ifdef KPD_GHOST_REJECT_EN
  logic [IW:0] ones;
  always_comb begin
    ones = '0;
    for (int i = 0; i < NK; i++) ones = ones + (IW + 1)'(raw_q[i]);
    ghost = (ones > (IW + 1)'(2));
  end
`else
  assign ghost = 1'b0;
`endif

  always_comb begin
    cnt_d = '0;
    if (!ghost && raw_q == prev_q)
      cnt_d = (cnt_q == BW'(DB_CNT)) ? cnt_q : cnt_q + 1'b1;
  end

  assign accept = do_eval && !ghost && (cnt_d == BW'(DB_CNT)) && (raw_q != key_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      state_q   <= DRIVE;
      col_q     <= '0;
      div_q     <= '0;
      active_q  <= 1'b0;
      raw_q     <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      key_state <= '0;
      key_evt   <= 1'b0;
    end else begin
      sync1_q  <= kpd_row_n;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      col_q    <= col_d;
      div_q    <= div_d;
      active_q <= scan_en;
      key_evt  <= accept;
      if (!scan_en) begin
        raw_q <= '0;
        cnt_q <= '0;
      end else begin
        raw_q <= raw_d;
        if (do_eval) begin
          cnt_q <= cnt_d;
          if (!ghost) prev_q <= raw_q;
          if (accept) key_state <= raw_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_kpd_scan.sv
// Directed bench for kpd_scan: ideal keypad model, frame-level reference model, per-cycle compare.
module tb_kpd_scan;
  localparam int ROWS = 4, COLS = 3, SD = 4, DB = 3;
  localparam int NK = ROWS * COLS;
  localparam int FRAME = COLS * (SD + 1) + 1;

  logic clk = 0, rst = 1, scan_en = 1;
  logic [ROWS-1:0] kpd_row_n;
  logic [COLS-1:0] kpd_col_n;
  logic [NK-1:0]   key_state;
  logic            key_any, key_evt;
  logic [NK-1:0]   keys = '0;

  int n_cmp = 0, n_err = 0;
  int evt_total = 0;
  bit cmp_on = 0;

  // reference model state (value valid during the current cycle)
  bit          act = 0;
  int          pos = 0;
  bit [NK-1:0] m_raw = '0, m_prev = '0, m_state = '0;
  int          m_cnt = 0;
  bit          m_evt = 0;

  kpd_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DB_CNT(DB)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .kpd_row_n(kpd_row_n),
    .kpd_col_n(kpd_col_n), .key_state(key_state), .key_any(key_any), .key_evt(key_evt)
  );

  always #5 clk = ~clk;

  // ideal switch matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    kpd_row_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !kpd_col_n[c]) kpd_row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_evt = 0;
    if (rst) begin
      act = 0; pos = 0; m_cnt = 0; m_prev = '0; m_state = '0; m_raw = '0;
    end else if (!scan_en) begin
      act = 0; pos = 0; m_cnt = 0;
    end else if (!act) begin
      act = 1; pos = 0;
    end else begin
      if (pos < FRAME - 1 && pos % (SD + 1) == SD)
        for (int r = 0; r < ROWS; r++) m_raw[r*COLS + pos/(SD+1)] = keys[r*COLS + pos/(SD+1)];
      if (pos == FRAME - 1) begin
`ifdef KPD_GHOST_REJECT_EN
        if ($countones(m_raw) > 2) m_cnt = 0;
        else begin
`endif
          m_cnt = (m_raw == m_prev) ? ((m_cnt < DB) ? m_cnt + 1 : DB) : 0;
          m_prev = m_raw;
          if (m_cnt == DB && m_raw != m_state) begin
            m_state = m_raw;
            m_evt = 1;
          end
`ifdef KPD_GHOST_REJECT_EN
        end
`endif
      end
      pos = (pos + 1) % FRAME;
    end
  end

  initial begin
    logic [COLS-1:0] exp_col;
    forever begin
      @(posedge clk);
      #1;
      if (key_evt === 1'b1) evt_total++;
      if (cmp_on) begin
        exp_col = '1;
        if (act && scan_en && pos < FRAME - 1 && pos % (SD + 1) != SD)
          exp_col[pos/(SD+1)] = 1'b0;
        chk("col_n", 32'(kpd_col_n), 32'(exp_col));
        chk("key_state", 32'(key_state), 32'(m_state));
        chk("key_any", 32'(key_any), 32'(|m_state));
        chk("key_evt", 32'(key_evt), 32'(m_evt));
      end
    end
  end

  task automatic wait_pos(input int p, input string name);
    bit hit = 0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (act && scan_en && pos == p) hit = 1;
    end
    if (!hit) chk({name, "_timeout"}, 0, 1);
  endtask

  // counts posedges from now; returns the index of the first key_evt and the pulse count
  task automatic run_cycles(input int n, output int first, output int nevt);
    first = 0; nevt = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (key_evt === 1'b1) begin
        nevt++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    int first, nevt, e0;
    repeat (3) @(negedge clk);
    cmp_on = 1;
    @(posedge clk); #1;
    chk("rst_state", 32'(key_state), 0);
    chk("rst_col", 32'(kpd_col_n), 32'h7);
    chk("rst_evt", 32'(key_evt), 0);

    // key 5 held from reset release
    @(negedge clk);
    keys = 12'h020;
    rst = 0;
    run_cycles(5 * FRAME, first, nevt);
    chk("press_first_evt", 32'(first), 65);
    chk("press_nevt", 32'(nevt), 1);
    chk("press_state", 32'(key_state), 32'h020);
    chk("press_any", 32'(key_any), 1);

    // release
    wait_pos(FRAME - 1, "rel");
    keys = '0;
    run_cycles(5 * FRAME, first, nevt);
    chk("rel_first_evt", 32'(first), 65);
    chk("rel_nevt", 32'(nevt), 1);
    chk("rel_state", 32'(key_state), 0);

    // chatter on key 0
    e0 = evt_total;
    for (int f = 0; f < 10; f++) begin
      wait_pos(FRAME - 1, "tog");
      keys[0] = ~keys[0];
    end
    run_cycles(2 * FRAME, first, nevt);
    chk("tog_nevt", 32'(evt_total - e0), 0);
    chk("tog_state", 32'(key_state), 0);

    // establish key 5, then pause scanning mid-frame
    wait_pos(FRAME - 1, "set5");
    keys = 12'h020;
    run_cycles(5 * FRAME, first, nevt);
    chk("set5_state", 32'(key_state), 32'h020);
    wait_pos(7, "pause");
    scan_en = 0;
    e0 = evt_total;
    repeat (5) begin
      @(posedge clk); #1;
      chk("pause_col", 32'(kpd_col_n), 32'h7);
    end
    @(negedge clk);
    scan_en = 1;
    @(posedge clk); #1;
    chk("resume_col0", 32'(kpd_col_n), 32'h6);
    run_cycles(5 * FRAME, first, nevt);
    chk("resume_state", 32'(key_state), 32'h020);
    chk("resume_nevt", 32'(evt_total - e0), 0);

    // reset mid-frame
    wait_pos(7, "rst_mid");
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstmid_state", 32'(key_state), 0);
    chk("rstmid_any", 32'(key_any), 0);
    chk("rstmid_col", 32'(kpd_col_n), 32'h7);
    chk("rstmid_evt", 32'(key_evt), 0);
    keys = '0;
    run_cycles(2 * FRAME, first, nevt);

`ifdef KPD_GHOST_REJECT_EN
    wait_pos(FRAME - 1, "ghost");
    keys = 12'h00B;
    e0 = evt_total;
    run_cycles(6 * FRAME - 1, first, nevt);
    chk("ghost_state", 32'(key_state), 0);
    chk("ghost_nevt", 32'(evt_total - e0), 0);
    wait_pos(FRAME - 1, "unghost");
    keys = 12'h003;
    run_cycles(5 * FRAME, first, nevt);
    chk("unghost_first", 32'(first), 65);
    chk("unghost_state", 32'(key_state), 32'h003);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kpd_scan.md
KPD_SCAN -- requirements
Module: kpd_scan

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows.
REQ-002 SHALL have parameter COLS, default 3, number of keypad columns.
REQ-003 SHALL have parameter SCAN_DIV, default 4, drive cycles per column before sampling; legal range is 4 or more.
REQ-004 SHALL have parameter DB_CNT, default 3, number of identical frames required to accept a change; legal range is 1 or more.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; every flop SHALL use its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port scan_en, input, 1 bit: scan enable.
REQ-008 SHALL have port kpd_row_n, input, ROWS bits: keypad row pins, active-low, asynchronous, externally pulled up.
REQ-009 SHALL have port kpd_col_n, output, COLS bits: column drive, active-low, one-hot-low while scanning.
REQ-010 SHALL have port key_state, output, ROWS*COLS bits: debounced key map; bit index is row*COLS+col.
REQ-011 SHALL have port key_any, output, 1 bit: OR-reduction of key_state.
REQ-012 SHALL have port key_evt, output, 1 bit: one-cycle pulse whenever key_state changes.
REQ-013 With the default parameters, key_state and key_any together (13 bits) SHALL connect directly to the GPIO block's 13-bit input-pin bus.

Function
REQ-014 kpd_row_n SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized copy.
REQ-015 The FSM SHALL have exactly three states: DRIVE, SAMPLE, EVAL.
REQ-016 DRIVE: kpd_col_n[col] SHALL be 0 and all other column bits 1; the state SHALL last SCAN_DIV cycles, then go to SAMPLE.
REQ-017 SAMPLE (1 cycle): raw[r*COLS+col] SHALL be loaded with the inverted synchronized row r.
- If col is less than COLS-1: col SHALL increment and the FSM SHALL return to DRIVE.
- Otherwise: the FSM SHALL go to EVAL.
REQ-018 EVAL (1 cycle): kpd_col_n SHALL be all 1s; col SHALL reset to 0 and the FSM SHALL return to DRIVE.
REQ-019 Frame length SHALL be COLS*(SCAN_DIV+1)+1 cycles; this is 16 cycles with the defaults.
REQ-020 EVAL debounce rule:
- If raw equals prev_raw: cnt SHALL increment, saturating at DB_CNT.
- Otherwise: cnt SHALL be set to 0.
- prev_raw SHALL then be loaded with raw.
REQ-021 In the EVAL where cnt becomes DB_CNT and raw differs from key_state:
- key_state SHALL be loaded with raw on the next edge.
- key_evt SHALL be 1 for exactly that following cycle.
REQ-022 A change SHALL therefore be accepted only after DB_CNT+1 consecutive identical frames; a raw pattern equal to the current key_state SHALL produce no key_evt.
REQ-023 While cnt is saturated and raw is unchanged, no further key_evt SHALL occur.
REQ-024 scan_en=0 SHALL take priority over the FSM:
- kpd_col_n SHALL be all 1s.
- The FSM SHALL be held in DRIVE with col=0 and the divider at 0.
- The raw bits of the partial frame SHALL be discarded.
- cnt SHALL be cleared.
- key_state SHALL be retained.
REQ-025 When scan_en rises, the first full frame SHALL start on the next cycle.
REQ-026 key_any SHALL be combinational from key_state.

Reset
REQ-027 rst=1 SHALL set, on the next edge:
- kpd_col_n to all 1s;
- FSM to DRIVE, col=0, divider=0;
- raw, prev_raw and cnt to 0;
- key_state to 0, key_any to 0, key_evt to 0;
- both synchronizer stages to all 1s.
REQ-028 rst SHALL dominate scan_en; asserting rst mid-frame SHALL abort the frame with no key_evt.

Configuration
REQ-029 Macro KPD_GHOST_REJECT_EN SHALL control ghost rejection.
- Defined: an EVAL whose raw has more than 2 bits set SHALL be treated as a mismatch (cnt set to 0, prev_raw not updated, key_state unchanged).
- Undefined: every frame SHALL be processed per REQ-020.

Verification
REQ-030 Defaults; hold key 5 pressed (row1 low while col2 driven) from reset release -> key_state=0x020, key_any=1, and key_evt pulses once, in the cycle after the 4th EVAL.
REQ-031 Key 5 held, then released -> key_state=0x000 and one key_evt after 4 released frames; no other pulses.
REQ-032 Toggle key 0 every frame for 10 frames -> cnt never exceeds 0, key_state stays 0x000, no key_evt.
REQ-033 Drop scan_en at cycle 7 of a frame, raise it 5 cycles later -> kpd_col_n=3'b111 while low; key_state retained; column 0 is driven the cycle after the rise.
REQ-034 With KPD_GHOST_REJECT_EN defined, press keys 0, 1 and 3 -> key_state stays 0x000; releasing key 3 -> 0x003 after 4 frames.
REQ-035 Pulse rst for 1 cycle mid-frame with key_state=0x020 -> all outputs 0, kpd_col_n=3'b111 on the next edge.
